// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// presents Instr to decode and resolves beq/bne to choose the next PC.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  input  logic        Branch,
  input  logic        BranchN,
  input  logic        Zero,
  input  logic [31:0] imm_ext,
  input  logic        stall,
  output logic        fault
);

  localparam int          CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [31:0] PC0     = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXEC, S_HALT} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   instr_q, instr_d;
  logic          vld_q, vld_d;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          taken;
  logic [31:0]   pc_plus4;

  assign pc_plus4    = pc_q + 32'd4;
  assign taken       = (Branch & Zero) | (BranchN & ~Zero);

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign Instr       = instr_q;
  assign instr_valid = vld_q;
  assign fault       = fault_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    vld_d   = vld_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // An ack on the final allowed cycle still counts as a successful fetch.
        if (imem_ack) begin
          instr_d = imem_rdata;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_MAX) begin
          fault_d = 1'b1;
          cnt_d   = '0;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d    = pc_plus4 + (taken ? {imm_ext[29:0], 2'b00} : 32'd0);
          vld_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= PC0;
      instr_q <= '0;
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      vld_q   <= vld_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
